// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multi-cycle MIPS datapath: fetch/decode/execute/mem/writeback sequencing.
// Latency: outputs are combinational from the state (and mem_ready in FETCH); lw 5, sw/R/addi 4, beq/j 3, illegal 2 cycles.
// Backpressure: mem_ready=0 holds FETCH, MEM_RD and MEM_WR one extra cycle each; other states ignore it.
module multicycle_control_unit #(
    parameter bit JUMP_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       instr_op,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             i_or_d,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic [CNT_W-1:0] retired
);

    localparam logic [3:0] S_FETCH     = 4'd0;
    localparam logic [3:0] S_DECODE    = 4'd1;
    localparam logic [3:0] S_MEM_ADDR  = 4'd2;
    localparam logic [3:0] S_MEM_RD    = 4'd3;
    localparam logic [3:0] S_MEM_WB    = 4'd4;
    localparam logic [3:0] S_MEM_WR    = 4'd5;
    localparam logic [3:0] S_R_EXEC    = 4'd6;
    localparam logic [3:0] S_R_WB      = 4'd7;
    localparam logic [3:0] S_BRANCH    = 4'd8;
    localparam logic [3:0] S_JUMP      = 4'd9;
    localparam logic [3:0] S_ADDI_EXEC = 4'd10;
    localparam logic [3:0] S_ADDI_WB   = 4'd11;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    logic [3:0]       state_q;
    logic [3:0]       state_nxt;
    logic [5:0]       op_q;
    logic             op_legal;
    logic             retire_evt;
    logic [CNT_W-1:0] retired_q;

    // Opcode legality as seen in DECODE; j only counts when jumps are built in
    always_comb begin
        op_legal = 1'b0;
        case (instr_op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI: op_legal = 1'b1;
            OP_J:                                    op_legal = JUMP_EN;
            default:                                 op_legal = 1'b0;
        endcase
    end

    // State, latched opcode and retired counter; reset aborts any in-flight instruction
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            retired_q <= '0;
        end else begin
            state_q <= state_nxt;
            if (state_q == S_DECODE) begin
                op_q <= instr_op;
            end
            if (retire_evt) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    // Next-state selection; MEM_ADDR uses the opcode captured in DECODE since the IR field may move on
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_FETCH:     state_nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (instr_op)
                    OP_RTYPE:      state_nxt = S_R_EXEC;
                    OP_LW, OP_SW:  state_nxt = S_MEM_ADDR;
                    OP_BEQ:        state_nxt = S_BRANCH;
                    OP_ADDI:       state_nxt = S_ADDI_EXEC;
                    OP_J:          state_nxt = JUMP_EN ? S_JUMP : S_FETCH;
                    default:       state_nxt = S_FETCH;
                endcase
            end
            S_MEM_ADDR:  state_nxt = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD:    state_nxt = mem_ready ? S_MEM_WB : S_MEM_RD;
            S_MEM_WB:    state_nxt = S_FETCH;
            S_MEM_WR:    state_nxt = mem_ready ? S_FETCH : S_MEM_WR;
            S_R_EXEC:    state_nxt = S_R_WB;
            S_R_WB:      state_nxt = S_FETCH;
            S_BRANCH:    state_nxt = S_FETCH;
            S_JUMP:      state_nxt = S_FETCH;
            S_ADDI_EXEC: state_nxt = S_ADDI_WB;
            S_ADDI_WB:   state_nxt = S_FETCH;
            default:     state_nxt = S_FETCH;
        endcase
    end

    // Moore outputs per state; everything is held low while reset is asserted
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        retire_evt    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: begin
                    alu_src_b  = 2'b11;
                    illegal_op = !op_legal;
                end
                S_MEM_ADDR, S_ADDI_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    mem_to_reg = 1'b1;
                    reg_write  = 1'b1;
                    retire_evt = 1'b1;
                end
                S_MEM_WR: begin
                    mem_write  = 1'b1;
                    i_or_d     = 1'b1;
                    retire_evt = mem_ready;
                end
                S_R_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_R_WB: begin
                    reg_dst    = 1'b1;
                    reg_write  = 1'b1;
                    retire_evt = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    retire_evt    = 1'b1;
                end
                S_JUMP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b10;
                    retire_evt = 1'b1;
                end
                S_ADDI_WB: begin
                    reg_write  = 1'b1;
                    retire_evt = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench: per-cycle vector table for the main instance, hand sequences for a no-jump, 2-bit-counter instance.
// Inputs driven on the falling edge, outputs compared 1 time unit later.
// No handshake waits; every sequence runs a fixed number of cycles.
module tb_multicycle_control_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // control word: {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
    //                mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal_op}
    localparam logic [16:0] C_ZERO      = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_FETCH_RDY = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_FETCH_STL = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
    localparam logic [16:0] C_DECODE    = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
    localparam logic [16:0] C_DEC_ILL   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_1;
    localparam logic [16:0] C_MEM_ADDR  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_MEM_RD    = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WB    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
    localparam logic [16:0] C_MEM_WR    = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
    localparam logic [16:0] C_R_EXEC    = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
    localparam logic [16:0] C_R_WB      = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
    localparam logic [16:0] C_BRANCH    = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
    localparam logic [16:0] C_JUMP      = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
    localparam logic [16:0] C_ADDI_EX   = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
    localparam logic [16:0] C_ADDI_WB   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

    localparam logic [5:0] RT = 6'b000000, LW = 6'b100011, SW = 6'b101011;
    localparam logic [5:0] BQ = 6'b000100, AI = 6'b001000, JJ = 6'b000010, XX = 6'b111111;

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic        mr;
        logic [3:0]  exp_state;
        logic [16:0] exp_ctrl;
        logic [15:0] exp_ret;
    } vec_t;

    // main instance, JUMP_EN=1, CNT_W=16
    logic        rst, mem_ready;
    logic [5:0]  instr_op;
    logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic        mem_to_reg, reg_dst, reg_write, alu_src_a, illegal_op;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
    logic [15:0] retired;

    multicycle_control_unit #(.JUMP_EN(1'b1), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .instr_op(instr_op), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .pc_source(pc_source), .state(state), .illegal_op(illegal_op), .retired(retired)
    );

    // second instance, JUMP_EN=0, CNT_W=2
    logic        rst2, mem_ready2;
    logic [5:0]  instr_op2;
    logic        pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2;
    logic        mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, illegal_op2;
    logic [1:0]  alu_src_b2, alu_op2, pc_source2;
    logic [3:0]  state2;
    logic [1:0]  retired2;

    multicycle_control_unit #(.JUMP_EN(1'b0), .CNT_W(2)) dut_nj (
        .clk(clk), .rst(rst2), .instr_op(instr_op2), .mem_ready(mem_ready2),
        .pc_write(pc_write2), .pc_write_cond(pc_write_cond2), .i_or_d(i_or_d2),
        .mem_read(mem_read2), .mem_write(mem_write2), .ir_write(ir_write2),
        .mem_to_reg(mem_to_reg2), .reg_dst(reg_dst2), .reg_write(reg_write2),
        .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
        .pc_source(pc_source2), .state(state2), .illegal_op(illegal_op2), .retired(retired2)
    );

    wire [16:0] ctrl  = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                         mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                         pc_source, illegal_op};
    wire [16:0] ctrl2 = {pc_write2, pc_write_cond2, i_or_d2, mem_read2, mem_write2, ir_write2,
                         mem_to_reg2, reg_dst2, reg_write2, alu_src_a2, alu_src_b2, alu_op2,
                         pc_source2, illegal_op2};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    vec_t vecs[38];

    initial begin
        // reset
        vecs[0]  = '{1'b1, RT, 1'b1, 4'd0,  C_ZERO,      16'd0};
        // R-type
        vecs[1]  = '{1'b0, RT, 1'b1, 4'd0,  C_FETCH_RDY, 16'd0};
        vecs[2]  = '{1'b0, RT, 1'b1, 4'd1,  C_DECODE,    16'd0};
        vecs[3]  = '{1'b0, RT, 1'b1, 4'd6,  C_R_EXEC,    16'd0};
        vecs[4]  = '{1'b0, RT, 1'b1, 4'd7,  C_R_WB,      16'd0};
        // lw, opcode changes after DECODE, two stall cycles in MEM_RD
        vecs[5]  = '{1'b0, LW, 1'b1, 4'd0,  C_FETCH_RDY, 16'd1};
        vecs[6]  = '{1'b0, LW, 1'b1, 4'd1,  C_DECODE,    16'd1};
        vecs[7]  = '{1'b0, RT, 1'b1, 4'd2,  C_MEM_ADDR,  16'd1};
        vecs[8]  = '{1'b0, RT, 1'b0, 4'd3,  C_MEM_RD,    16'd1};
        vecs[9]  = '{1'b0, RT, 1'b0, 4'd3,  C_MEM_RD,    16'd1};
        vecs[10] = '{1'b0, RT, 1'b1, 4'd3,  C_MEM_RD,    16'd1};
        vecs[11] = '{1'b0, RT, 1'b0, 4'd4,  C_MEM_WB,    16'd1};
        // fetch stall, then sw with a stall in MEM_WR
        vecs[12] = '{1'b0, SW, 1'b0, 4'd0,  C_FETCH_STL, 16'd2};
        vecs[13] = '{1'b0, SW, 1'b1, 4'd0,  C_FETCH_RDY, 16'd2};
        vecs[14] = '{1'b0, SW, 1'b1, 4'd1,  C_DECODE,    16'd2};
        vecs[15] = '{1'b0, SW, 1'b1, 4'd2,  C_MEM_ADDR,  16'd2};
        vecs[16] = '{1'b0, SW, 1'b0, 4'd5,  C_MEM_WR,    16'd2};
        vecs[17] = '{1'b0, SW, 1'b1, 4'd5,  C_MEM_WR,    16'd2};
        // beq
        vecs[18] = '{1'b0, BQ, 1'b1, 4'd0,  C_FETCH_RDY, 16'd3};
        vecs[19] = '{1'b0, BQ, 1'b1, 4'd1,  C_DECODE,    16'd3};
        vecs[20] = '{1'b0, BQ, 1'b1, 4'd8,  C_BRANCH,    16'd3};
        // j
        vecs[21] = '{1'b0, JJ, 1'b1, 4'd0,  C_FETCH_RDY, 16'd4};
        vecs[22] = '{1'b0, JJ, 1'b1, 4'd1,  C_DECODE,    16'd4};
        vecs[23] = '{1'b0, JJ, 1'b1, 4'd9,  C_JUMP,      16'd4};
        // addi
        vecs[24] = '{1'b0, AI, 1'b1, 4'd0,  C_FETCH_RDY, 16'd5};
        vecs[25] = '{1'b0, AI, 1'b1, 4'd1,  C_DECODE,    16'd5};
        vecs[26] = '{1'b0, AI, 1'b1, 4'd10, C_ADDI_EX,   16'd5};
        vecs[27] = '{1'b0, AI, 1'b1, 4'd11, C_ADDI_WB,   16'd5};
        // illegal opcode
        vecs[28] = '{1'b0, XX, 1'b1, 4'd0,  C_FETCH_RDY, 16'd6};
        vecs[29] = '{1'b0, XX, 1'b1, 4'd1,  C_DEC_ILL,   16'd6};
        // lw aborted by reset in MEM_RD
        vecs[30] = '{1'b0, LW, 1'b1, 4'd0,  C_FETCH_RDY, 16'd6};
        vecs[31] = '{1'b0, LW, 1'b1, 4'd1,  C_DECODE,    16'd6};
        vecs[32] = '{1'b0, LW, 1'b1, 4'd2,  C_MEM_ADDR,  16'd6};
        vecs[33] = '{1'b0, LW, 1'b0, 4'd3,  C_MEM_RD,    16'd6};
        vecs[34] = '{1'b1, LW, 1'b1, 4'd3,  C_ZERO,      16'd6};
        vecs[35] = '{1'b1, LW, 1'b1, 4'd0,  C_ZERO,      16'd0};
        vecs[36] = '{1'b0, RT, 1'b1, 4'd0,  C_FETCH_RDY, 16'd0};
        vecs[37] = '{1'b0, RT, 1'b1, 4'd1,  C_DECODE,    16'd0};

        rst = 1'b1; instr_op = 6'd0; mem_ready = 1'b0;
        rst2 = 1'b1; instr_op2 = 6'd0; mem_ready2 = 1'b0;
        @(negedge clk);
        @(negedge clk);

        for (int i = 0; i < 38; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; instr_op = vecs[i].op; mem_ready = vecs[i].mr;
            #1;
            check("state",   i, 32'(state),   32'(vecs[i].exp_state));
            check("ctrl",    i, 32'(ctrl),    32'(vecs[i].exp_ctrl));
            check("retired", i, 32'(retired), 32'(vecs[i].exp_ret));
        end

        // no-jump instance: j is illegal, then four beq wrap the 2-bit counter
        @(negedge clk);
        rst2 = 1'b0; instr_op2 = JJ; mem_ready2 = 1'b1;
        #1;
        check("nj_fetch_state", 0, 32'(state2), 32'd0);
        @(negedge clk); #1;
        check("nj_dec_state",   0, 32'(state2), 32'd1);
        check("nj_dec_ctrl",    0, 32'(ctrl2),  32'(C_DEC_ILL));
        @(negedge clk); #1;
        check("nj_back_state",  0, 32'(state2), 32'd0);
        check("nj_no_pulse",    0, 32'(illegal_op2), 32'd0);
        check("nj_retired",     0, 32'(retired2), 32'd0);
        instr_op2 = BQ;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk); #1;
            check("nj_beq_dec",    k, 32'(state2), 32'd1);
            @(negedge clk); #1;
            check("nj_beq_branch", k, 32'(state2), 32'd8);
            @(negedge clk); #1;
            check("nj_beq_ret",    k, 32'(retired2), 32'((k + 1) % 4));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
